// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM state encoding
// and default geometry.
package psum_pkg;

  localparam int PSUM_DWIDTH   = 32;
  localparam int PSUM_AWIDTH   = 4;
  localparam int PSUM_MEM_SIZE = 16;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/psum_adder.sv
// Signed accumulate adder; a first beat passes data straight through.
// Define PSUM_SAT_EN to clamp overflow to the signed range instead of wrapping.
module psum_adder #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] acc,
  input  logic [DWIDTH-1:0] data,
  input  logic              first,
  output logic [DWIDTH-1:0] sum
);

  logic [DWIDTH-1:0] raw;

  assign raw = acc + data;

`ifdef PSUM_SAT_EN
  logic ovf_pos;
  logic ovf_neg;

  // Overflow only when both operands share a sign that the result lost.
  assign ovf_pos = !acc[DWIDTH-1] && !data[DWIDTH-1] &&  raw[DWIDTH-1];
  assign ovf_neg =  acc[DWIDTH-1] &&  data[DWIDTH-1] && !raw[DWIDTH-1];

  always_comb begin
    sum = raw;
    if (first)
      sum = data;
    else if (ovf_pos)
      sum = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (ovf_neg)
      sum = {1'b1, {(DWIDTH-1){1'b0}}};
  end
`else
  assign sum = first ? data : raw;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Read-modify-write partial-sum accumulator over an external 2-port RAM.
// Saturating add is selected with the PSUM_SAT_EN macro (see psum_adder).
//
// state | meaning
// ACC   | accept beats, one per cycle, 2-stage read/accumulate/write
// DRAIN | retire the beat still held in S1 before clearing
// CLEAR | write zero to every RAM word, one address per cycle
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int DWIDTH   = PSUM_DWIDTH,
  parameter int AWIDTH   = PSUM_AWIDTH,
  parameter int MEM_SIZE = PSUM_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_first,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  input  logic [DWIDTH-1:0] q0,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  output logic              we1,
  output logic [DWIDTH-1:0] d1
);

  state_t state, state_next;

  logic              accept;
  logic              s1_valid;
  logic [AWIDTH-1:0] s1_addr;
  logic [DWIDTH-1:0] s1_data;
  logic              s1_first;
  logic              s1_write;

  logic              wb_valid;
  logic [AWIDTH-1:0] wb_addr;
  logic [DWIDTH-1:0] wb_sum;

  logic [DWIDTH-1:0] operand;
  logic [DWIDTH-1:0] sum;
  logic [AWIDTH-1:0] clr_cnt;
  logic              clr_last;

  assign in_ready = (state == ACC) && !clear_start;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == DRAIN) || (state == CLEAR);
  assign ce0      = accept;
  assign addr0    = in_addr;
  assign we0      = 1'b0;
  assign clr_last = (clr_cnt == AWIDTH'(MEM_SIZE - 1));

  // The RAM read for S1 was issued before the previous write landed, so the
  // last written sum is forwarded when it targets the same word.
  assign operand = (wb_valid && (wb_addr == s1_addr)) ? wb_sum : q0;

  psum_adder #(.DWIDTH(DWIDTH)) u_adder (
    .acc   (operand),
    .data  (s1_data),
    .first (s1_first),
    .sum   (sum)
  );

  always_comb begin
    state_next = state;
    s1_write   = 1'b0;
    ce1        = 1'b0;
    we1        = 1'b0;
    addr1      = s1_addr;
    d1         = sum;
    case (state)
      ACC: begin
        s1_write = s1_valid;
        if (clear_start)
          state_next = s1_valid ? DRAIN : CLEAR;
      end
      DRAIN: begin
        s1_write   = s1_valid;
        state_next = CLEAR;
      end
      CLEAR: begin
        ce1   = 1'b1;
        we1   = 1'b1;
        addr1 = clr_cnt;
        d1    = '0;
        if (clr_last)
          state_next = ACC;
      end
      default: state_next = ACC;
    endcase
    if (s1_write) begin
      ce1 = 1'b1;
      we1 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACC;
      s1_valid   <= 1'b0;
      wb_valid   <= 1'b0;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      s1_valid   <= accept;
      wb_valid   <= s1_write;
      clear_done <= (state == CLEAR) && clr_last;
      if (state == CLEAR && !clr_last)
        clr_cnt <= clr_cnt + 1'b1;
      else
        clr_cnt <= '0;
    end
  end

  // Datapath registers are qualified by their valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr  <= in_addr;
      s1_data  <= in_data;
      s1_first <= in_first;
    end
    if (s1_write) begin
      wb_addr <= addr1;
      wb_sum  <= d1;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator with a behavioural 2-port RAM and
// a write scoreboard; compile with PSUM_SAT_EN to exercise saturation.
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          clear_done;
  logic [AW-1:0] addr0;
  logic          ce0;
  logic          we0;
  logic [DW-1:0] q0;
  logic [AW-1:0] addr1;
  logic          ce1;
  logic          we1;
  logic [DW-1:0] d1;

  logic [DW-1:0] tb_mem  [MS];
  logic [DW-1:0] ref_mem [MS];
  wr_t           exp_q[$];
  int            pass_cnt = 0;
  int            check_cnt = 0;

  psum_accumulator #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_first    (in_first),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .addr0       (addr0),
    .ce0         (ce0),
    .we0         (we0),
    .q0          (q0),
    .addr1       (addr1),
    .ce1         (ce1),
    .we1         (we1),
    .d1          (d1)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM: a same-edge read returns the old word.
  always @(posedge clk) begin
    if (ce0 === 1'b1) q0 <= tb_mem[addr0];
    if (ce1 === 1'b1 && we1 === 1'b1) tb_mem[addr1] <= d1;
  end

  always @(negedge clk) begin
    wr_t e;
    if (ce1 === 1'b1 && we1 === 1'b1) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected_write addr=%0d data=%h required no write", addr1, d1);
      end else begin
        e = exp_q.pop_front();
        if (addr1 !== e.addr || d1 !== e.data)
          $display("FAIL scoreboard_write got addr=%0d data=%h required addr=%0d data=%h",
                   addr1, d1, e.addr, e.data);
        else
          pass_cnt++;
      end
    end
  end

  function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] old,
                                              input logic [DW-1:0] data,
                                              input logic first);
    longint s;
    if (first) return data;
    s = longint'(signed'(old)) + longint'(signed'(data));
`ifdef PSUM_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[DW-1:0];
  endfunction

  task automatic drive_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
    wr_t e;
    in_valid   = 1'b1;
    in_addr    = a;
    in_data    = d;
    in_first   = f;
    ref_mem[a] = model_sum(ref_mem[a], d, f);
    e.addr     = a;
    e.data     = ref_mem[a];
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_zero_writes(input int upto);
    wr_t e;
    for (int i = 0; i <= upto; i++) begin
      e.addr     = AW'(i);
      e.data     = '0;
      ref_mem[i] = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(output bit timed_out);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    timed_out = (exp_q.size() != 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (ce0 !== 1'b0) $display("FAIL reset_ce0 got=%b want=0", ce0); else pass_cnt++;
    check_cnt++; if (ce1 !== 1'b0) $display("FAIL reset_ce1 got=%b want=0", ce1); else pass_cnt++;
    check_cnt++; if (we1 !== 1'b0) $display("FAIL reset_we1 got=%b want=0", we1); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    check_cnt++; if (clear_done !== 1'b0) $display("FAIL reset_clear_done got=%b want=0", clear_done); else pass_cnt++;
    check_cnt++; if (we0 !== 1'b0) $display("FAIL reset_we0 got=%b want=0", we0); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_clear_idle;
    int cyc = 0;
    int bad_busy = 0;
    bit done = 0;
    bit to;
    push_zero_writes(MS - 1);
    clear_start = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      clear_start = 1'b0;
      if (clear_done === 1'b1) done = 1;
      else if (busy !== 1'b1) bad_busy++;
    end
    check_cnt++; if (!done || cyc != 17) $display("FAIL clear_idle_latency got=%0d want=17", cyc); else pass_cnt++;
    check_cnt++; if (bad_busy != 0) $display("FAIL clear_idle_busy low_cycles=%0d want=0", bad_busy); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL clear_idle_busy_end got=%b want=0", busy); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (clear_done !== 1'b0) $display("FAIL clear_done_pulse got=%b want=0", clear_done); else pass_cnt++;
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL clear_idle_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit to;
    int not_ready = 0;
    if (in_ready !== 1'b1) not_ready++;
    drive_beat(4'd3, 32'd5, 1'b1);
    if (in_ready !== 1'b1) not_ready++;
    drive_beat(4'd3, 32'd7, 1'b0);
    if (in_ready !== 1'b1) not_ready++;
    drive_beat(4'd3, -32'sd2, 1'b0);
    check_cnt++; if (not_ready != 0) $display("FAIL b2b_in_ready low_cycles=%0d want=0", not_ready); else pass_cnt++;
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL b2b_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (tb_mem[3] !== 32'd10) $display("FAIL b2b_ram3 got=%h want=%h", tb_mem[3], 32'd10); else pass_cnt++;
  endtask

  task automatic test_interleave;
    bit to;
    drive_beat(4'd1, 32'd4, 1'b0);
    drive_beat(4'd2, 32'd6, 1'b0);
    drive_beat(4'd1, 32'd1, 1'b0);
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL interleave_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (tb_mem[1] !== 32'd5) $display("FAIL interleave_ram1 got=%h want=%h", tb_mem[1], 32'd5); else pass_cnt++;
    check_cnt++; if (tb_mem[2] !== 32'd6) $display("FAIL interleave_ram2 got=%h want=%h", tb_mem[2], 32'd6); else pass_cnt++;
  endtask

  task automatic test_saturation;
    bit to;
    logic [DW-1:0] want_pos, want_neg;
`ifdef PSUM_SAT_EN
    want_pos = 32'h7FFF_FFFF;
    want_neg = 32'h8000_0000;
`else
    want_pos = 32'h8000_0010;
    want_neg = 32'h7FFF_FFF0;
`endif
    drive_beat(4'd0, 32'h7FFF_FFF0, 1'b1);
    drive_beat(4'd0, 32'h0000_0020, 1'b0);
    drive_beat(4'd4, 32'h8000_0010, 1'b1);
    drive_beat(4'd4, 32'hFFFF_FFE0, 1'b0);
    drive_beat(4'd7, 32'h7FFF_FFFF, 1'b1);
    drive_beat(4'd7, 32'h8000_0000, 1'b1);
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL sat_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    check_cnt++; if (tb_mem[0] !== want_pos) $display("FAIL sat_pos got=%h want=%h", tb_mem[0], want_pos); else pass_cnt++;
    check_cnt++; if (tb_mem[4] !== want_neg) $display("FAIL sat_neg got=%h want=%h", tb_mem[4], want_neg); else pass_cnt++;
    check_cnt++; if (tb_mem[7] !== 32'h8000_0000) $display("FAIL first_no_sat got=%h want=%h", tb_mem[7], 32'h8000_0000); else pass_cnt++;
  endtask

  task automatic test_clear_during_pipe;
    int cyc = 0;
    int bad_busy = 0;
    bit done = 0;
    bit to;
    drive_beat(4'd5, 32'd9, 1'b0);
    push_zero_writes(MS - 1);
    in_valid    = 1'b1;
    in_addr     = 4'd6;
    in_data     = 32'd77;
    in_first    = 1'b1;
    clear_start = 1'b1;
    #1;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL pipe_clear_in_ready got=%b want=0", in_ready); else pass_cnt++;
    check_cnt++; if (ce0 !== 1'b0) $display("FAIL pipe_clear_ce0 got=%b want=0", ce0); else pass_cnt++;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      clear_start = 1'b0;
      in_valid    = 1'b0;
      if (clear_done === 1'b1) done = 1;
      else if (busy !== 1'b1) bad_busy++;
    end
    check_cnt++; if (!done || cyc != 18) $display("FAIL pipe_clear_latency got=%0d want=18", cyc); else pass_cnt++;
    check_cnt++; if (bad_busy != 0) $display("FAIL pipe_clear_busy low_cycles=%0d want=0", bad_busy); else pass_cnt++;
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL pipe_clear_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    // Stale forwarding from the drained write must not leak into this beat.
    drive_beat(4'd5, 32'd3, 1'b0);
    wait_drain(to);
    check_cnt++; if (tb_mem[5] !== 32'd3) $display("FAIL post_clear_fwd got=%h want=%h", tb_mem[5], 32'd3); else pass_cnt++;
  endtask

  task automatic test_random;
    bit to;
    for (int i = 0; i < 60; i++) begin
      drive_beat(AW'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL random_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    for (int i = 0; i < MS; i++) begin
      check_cnt++;
      if (tb_mem[i] !== ref_mem[i]) $display("FAIL random_ram[%0d] got=%h want=%h", i, tb_mem[i], ref_mem[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_clear;
    bit to;
    bit hit = 0;
    int cyc = 0;
    for (int i = 0; i < MS; i++) drive_beat(AW'(i), 32'h0000_1000 + i, 1'b1);
    wait_drain(to);
    check_cnt++; if (to) $display("FAIL rst_fill_drain pending=%0d want=0", exp_q.size()); else pass_cnt++;
    push_zero_writes(6);
    clear_start = 1'b1;
    while (!hit && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      clear_start = 1'b0;
      if (ce1 === 1'b1 && busy === 1'b1 && addr1 == 4'd6) begin
        rst_n = 1'b0;
        hit   = 1;
      end
    end
    check_cnt++; if (!hit) $display("FAIL rst_mid_clear_reach got=0 want=1"); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (ce1 !== 1'b0) $display("FAIL rst_mid_clear_ce1 got=%b want=0", ce1); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_clear_busy got=%b want=0", busy); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_clear_in_ready got=%b want=1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (exp_q.size() != 0) $display("FAIL rst_mid_clear_pending got=%0d want=0", exp_q.size()); else pass_cnt++;
    for (int i = 0; i < MS; i++) begin
      check_cnt++;
      if (tb_mem[i] !== ref_mem[i]) $display("FAIL rst_mid_clear_ram[%0d] got=%h want=%h", i, tb_mem[i], ref_mem[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    test_reset();
    test_clear_idle();
    test_back_to_back();
    test_interleave();
    test_saturation();
    test_clear_during_pipe();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout checks=%0d passed=%0d", check_cnt, pass_cnt);
    $fatal(1, "timeout");
  end

endmodule
